mult_2: RTL

MULT_2 -- requirements
Module: Mult_2

---
 rtl/mult_2.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mult_2.sv
// Radix-4 iterative 32x32 unsigned multiplier: 16 cycles/op, m2_stall high during CALC, one-cycle m2_m3_oper pulse.
// Define MULT2_ZERO_BYPASS_EN so that requests flagged iszero finish in one cycle with a zero product.
module mult_2 (
  input  logic        clock,
  input  logic        reset,
  input  logic        m1_m2_oper,
  input  logic [31:0] m1_m2_rega,
  input  logic [31:0] m1_m2_regb,
  input  logic [4:0]  m1_m2_regdest,
  input  logic        m1_m2_ispositive,
  input  logic        m1_m2_iszero,
  output logic        m2_stall,
  output logic        m2_m3_oper,
  output logic [63:0] m2_m3_multres,
  output logic [4:0]  m2_m3_regdest,
  output logic        m2_m3_ispositive,
  output logic        m2_m3_iszero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [4:0]  rd_q, rd_d;
  logic        pos_q, pos_d;
  logic        zero_q, zero_d;
  logic [63:0] res_q, res_d;
  logic [4:0]  ord_q, ord_d;
  logic        opos_q, opos_d;
  logic        ozero_q, ozero_d;
  logic        oper_q, oper_d;
  logic [63:0] pp;
  logic [63:0] sum;

  // Partial product for one radix-4 digit of the multiplier.
  always_comb begin
    pp = 64'd0;
    case (mplier_q[1:0])
      2'd0: pp = 64'd0;
      2'd1: pp = mcand_q;
      2'd2: pp = mcand_q << 1;
      2'd3: pp = mcand_q + (mcand_q << 1);
      default: pp = 64'd0;
    endcase
    sum = acc_q + pp;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rd_d     = rd_q;
    pos_d    = pos_q;
    zero_d   = zero_q;
    res_d    = res_q;
    ord_d    = ord_q;
    opos_d   = opos_q;
    ozero_d  = ozero_q;
    oper_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (m1_m2_oper) begin
          state_d  = CALC;
          cnt_d    = 4'd0;
          acc_d    = 64'd0;
          mcand_d  = {32'd0, m1_m2_rega};
          mplier_d = m1_m2_regb;
          rd_d     = m1_m2_regdest;
          pos_d    = m1_m2_ispositive;
          zero_d   = m1_m2_iszero;
`ifdef MULT2_ZERO_BYPASS_EN
          if (m1_m2_iszero) begin
            state_d = DONE;
            res_d   = 64'd0;
            ord_d   = m1_m2_regdest;
            opos_d  = m1_m2_ispositive;
            ozero_d = 1'b1;
            oper_d  = 1'b1;
          end
`else
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 2;
        mplier_d = mplier_q >> 2;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = DONE;
          res_d   = sum;
          ord_d   = rd_q;
          opos_d  = pos_q;
          ozero_d = zero_q;
          oper_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      rd_q     <= 5'd0;
      pos_q    <= 1'b0;
      zero_q   <= 1'b0;
      res_q    <= 64'd0;
      ord_q    <= 5'd0;
      opos_q   <= 1'b0;
      ozero_q  <= 1'b0;
      oper_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rd_q     <= rd_d;
      pos_q    <= pos_d;
      zero_q   <= zero_d;
      res_q    <= res_d;
      ord_q    <= ord_d;
      opos_q   <= opos_d;
      ozero_q  <= ozero_d;
      oper_q   <= oper_d;
    end
  end

  assign m2_stall         = (state_q == CALC);
  assign m2_m3_oper       = oper_q;
  assign m2_m3_multres    = res_q;
  assign m2_m3_regdest    = ord_q;
  assign m2_m3_ispositive = opos_q;
  assign m2_m3_iszero     = ozero_q;

endmodule
